// File: rtl/trap_pkg.sv
// Shared types and constants for the trap controller: FSM states, event
// kinds, privilege encodings, CSR addresses and cause codes.
package trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // What the latched event will do at commit time.
    typedef enum logic [1:0] {
        KIND_EXC  = 2'd0,
        KIND_MRET = 2'd1,
        KIND_INT  = 2'd2
    } kind_t;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_MSI     = 4'd3;
    localparam logic [3:0] CAUSE_MTI     = 4'd7;
    localparam logic [3:0] CAUSE_MEI     = 4'd11;

    // Only U and M exist; any other encoding collapses to U.
    function automatic logic [1:0] legal_priv(input logic [1:0] mode);
        return (mode == PRIV_M) ? PRIV_M : PRIV_U;
    endfunction

endpackage

// File: rtl/trap_priority_sel.sv
// Combinational event arbitration: exception > mret > MEI > MSI > MTI.
// Produces the winning event's kind, cause code and tval. An mret from
// U mode is turned into an illegal-instruction exception.
module trap_priority_sel
    import trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_exc,
    input  logic [3:0]      i_excCause,
    input  logic [XLEN-1:0] i_excTval,
    input  logic            i_mret,
    input  logic            i_meip,
    input  logic            i_msip,
    input  logic            i_mtip,
    input  logic            i_mieMeie,
    input  logic            i_mieMsie,
    input  logic            i_mieMtie,
    input  logic            i_mstatusMie,
    input  logic [1:0]      i_nowPrivMode,
    output logic            o_valid,
    output kind_t           o_kind,
    output logic [3:0]      o_code,
    output logic [XLEN-1:0] o_tval
);

    logic w_intEn;
    logic w_meiPend;
    logic w_msiPend;
    logic w_mtiPend;

    assign w_intEn   = (i_nowPrivMode == PRIV_U) ||
                       ((i_nowPrivMode == PRIV_M) && i_mstatusMie);
    assign w_meiPend = w_intEn && i_meip && i_mieMeie;
    assign w_msiPend = w_intEn && i_msip && i_mieMsie;
    assign w_mtiPend = w_intEn && i_mtip && i_mieMtie;

    // Fixed-priority select of the highest event this cycle.
    always_comb begin
        o_valid = 1'b0;
        o_kind  = KIND_EXC;
        o_code  = 4'd0;
        o_tval  = '0;
        if (i_exc) begin
            o_valid = 1'b1;
            o_kind  = KIND_EXC;
            o_code  = i_excCause;
            o_tval  = i_excTval;
        end else if (i_mret) begin
            o_valid = 1'b1;
            if (i_nowPrivMode == PRIV_U) begin
                o_kind = KIND_EXC;
                o_code = CAUSE_ILLEGAL;
            end else begin
                o_kind = KIND_MRET;
            end
        end else if (w_meiPend) begin
            o_valid = 1'b1;
            o_kind  = KIND_INT;
            o_code  = CAUSE_MEI;
        end else if (w_msiPend) begin
            o_valid = 1'b1;
            o_kind  = KIND_INT;
            o_code  = CAUSE_MSI;
        end else if (w_mtiPend) begin
            o_valid = 1'b1;
            o_kind  = KIND_INT;
            o_code  = CAUSE_MTI;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// Privilege-mode change sequencer: IDLE -> DRAIN -> COMMIT. Latches the
// winning event, holds the pipeline until it drains, then redirects fetch,
// loads the privilege register and updates the trap CSRs in one cycle.
// Optional build macro TRAP_VECTORED_EN enables vectored interrupt targets.
module trap_controller
    import trap_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            reset_x,
    input  logic            i_exc,
    input  logic [3:0]      i_excCause,
    input  logic [XLEN-1:0] i_excTval,
    input  logic            i_mret,
    input  logic [XLEN-1:0] i_epc,
    input  logic            i_meip,
    input  logic            i_msip,
    input  logic            i_mtip,
    input  logic [1:0]      i_nowPrivMode,
    input  logic            i_pipeIdle,
    input  logic            i_csrWe,
    input  logic [11:0]     i_csrAddr,
    input  logic [XLEN-1:0] i_csrWdata,
    output logic [XLEN-1:0] o_csrRdata,
    output logic            o_stall,
    output logic            o_flush,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirectPc,
    output logic            o_privEnable,
    output logic [1:0]      o_nextPrivMode
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    state_t          r_state;
    state_t          w_nextState;

    // Latched event
    kind_t           r_kind;
    logic [3:0]      r_code;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_tval;
    logic [1:0]      r_prevMode;

    // Trap CSRs
    logic            r_mstatusMie;
    logic            r_mpie;
    logic [1:0]      r_mpp;
    logic            r_mieMeie;
    logic            r_mieMsie;
    logic            r_mieMtie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;

    logic            w_evValid;
    kind_t           w_evKind;
    logic [3:0]      w_evCode;
    logic [XLEN-1:0] w_evTval;
    logic [XLEN-1:0] w_trapTarget;
    logic [XLEN-1:0] w_commitCause;
    logic [XLEN-1:0] w_mtvecWr;
    logic [XLEN-1:0] w_mtvecRst;

    trap_priority_sel #(.XLEN(XLEN)) u_sel (
        .i_exc         (i_exc),
        .i_excCause    (i_excCause),
        .i_excTval     (i_excTval),
        .i_mret        (i_mret),
        .i_meip        (i_meip),
        .i_msip        (i_msip),
        .i_mtip        (i_mtip),
        .i_mieMeie     (r_mieMeie),
        .i_mieMsie     (r_mieMsie),
        .i_mieMtie     (r_mieMtie),
        .i_mstatusMie  (r_mstatusMie),
        .i_nowPrivMode (i_nowPrivMode),
        .o_valid       (w_evValid),
        .o_kind        (w_evKind),
        .o_code        (w_evCode),
        .o_tval        (w_evTval)
    );

    assign w_commitCause = {(r_kind == KIND_INT), {(XLEN-5){1'b0}}, r_code};

`ifdef TRAP_VECTORED_EN
    // Mode field keeps 00/01; reserved 1x encodings fall back to direct.
    assign w_mtvecWr  = {i_csrWdata[XLEN-1:2],
                         (i_csrWdata[1:0] == 2'b01) ? 2'b01 : 2'b00};
    assign w_mtvecRst = {MTVEC_RESET[XLEN-1:2],
                         (MTVEC_RESET[1:0] == 2'b01) ? 2'b01 : 2'b00};
    assign w_trapTarget = ((r_mtvec[1:0] == 2'b01) && (r_kind == KIND_INT))
                        ? (r_mtvec & ALIGN_MASK) + XLEN'({r_code, 2'b00})
                        : (r_mtvec & ALIGN_MASK);
`else
    assign w_mtvecWr    = i_csrWdata & ALIGN_MASK;
    assign w_mtvecRst   = MTVEC_RESET & ALIGN_MASK;
    assign w_trapTarget = r_mtvec & ALIGN_MASK;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) r_state <= ST_IDLE;
        else          r_state <= w_nextState;
    end

    // Next-state logic; events only start a sequence from IDLE
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:   if (w_evValid)  w_nextState = ST_DRAIN;
            ST_DRAIN:  if (i_pipeIdle) w_nextState = ST_COMMIT;
            ST_COMMIT: w_nextState = ST_IDLE;
            default:   w_nextState = ST_IDLE;
        endcase
    end

    // Outputs; redirect/privilege load are COMMIT-only, zero otherwise
    always_comb begin
        o_stall        = 1'b0;
        o_flush        = 1'b0;
        o_redirect     = 1'b0;
        o_redirectPc   = '0;
        o_privEnable   = 1'b0;
        o_nextPrivMode = PRIV_U;
        case (r_state)
            ST_DRAIN: begin
                o_stall = 1'b1;
                o_flush = 1'b1;
            end
            ST_COMMIT: begin
                o_stall      = 1'b1;
                o_redirect   = 1'b1;
                o_privEnable = 1'b1;
                if (r_kind == KIND_MRET) begin
                    o_redirectPc   = r_mepc;
                    o_nextPrivMode = r_mpp;
                end else begin
                    o_redirectPc   = w_trapTarget;
                    o_nextPrivMode = PRIV_M;
                end
            end
            default: ;
        endcase
    end

    // Capture the winning event as the sequence starts
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_kind     <= KIND_EXC;
            r_code     <= 4'd0;
            r_epc      <= '0;
            r_tval     <= '0;
            r_prevMode <= PRIV_U;
        end else if (r_state == ST_IDLE && w_evValid) begin
            r_kind     <= w_evKind;
            r_code     <= w_evCode;
            r_epc      <= i_epc;
            r_tval     <= w_evTval;
            r_prevMode <= i_nowPrivMode;
        end
    end

    // CSR state: commit updates at the end of COMMIT, software writes in IDLE
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_mstatusMie <= 1'b0;
            r_mpie       <= 1'b0;
            r_mpp        <= PRIV_M;
            r_mieMeie    <= 1'b0;
            r_mieMsie    <= 1'b0;
            r_mieMtie    <= 1'b0;
            r_mtvec      <= w_mtvecRst;
            r_mepc       <= '0;
            r_mcause     <= '0;
            r_mtval      <= '0;
        end else if (r_state == ST_COMMIT) begin
            if (r_kind == KIND_MRET) begin
                r_mstatusMie <= r_mpie;
                r_mpie       <= 1'b1;
                r_mpp        <= PRIV_U;
            end else begin
                r_mpp        <= legal_priv(r_prevMode);
                r_mpie       <= r_mstatusMie;
                r_mstatusMie <= 1'b0;
                r_mepc       <= r_epc & ALIGN_MASK;
                r_mcause     <= w_commitCause;
                r_mtval      <= r_tval;
            end
        end else if (r_state == ST_IDLE && i_csrWe) begin
            case (i_csrAddr)
                CSR_MSTATUS: begin
                    r_mstatusMie <= i_csrWdata[3];
                    r_mpie       <= i_csrWdata[7];
                    r_mpp        <= legal_priv(i_csrWdata[12:11]);
                end
                CSR_MIE: begin
                    r_mieMsie <= i_csrWdata[3];
                    r_mieMtie <= i_csrWdata[7];
                    r_mieMeie <= i_csrWdata[11];
                end
                CSR_MTVEC:  r_mtvec  <= w_mtvecWr;
                CSR_MEPC:   r_mepc   <= i_csrWdata & ALIGN_MASK;
                CSR_MCAUSE: r_mcause <= i_csrWdata;
                CSR_MTVAL:  r_mtval  <= i_csrWdata;
                default: ;
            endcase
        end
    end

    // Combinational CSR read; mip mirrors the live lines
    always_comb begin
        o_csrRdata = '0;
        case (i_csrAddr)
            CSR_MSTATUS: begin
                o_csrRdata[3]     = r_mstatusMie;
                o_csrRdata[7]     = r_mpie;
                o_csrRdata[12:11] = r_mpp;
            end
            CSR_MIE: begin
                o_csrRdata[3]  = r_mieMsie;
                o_csrRdata[7]  = r_mieMtie;
                o_csrRdata[11] = r_mieMeie;
            end
            CSR_MIP: begin
                o_csrRdata[3]  = i_msip;
                o_csrRdata[7]  = i_mtip;
                o_csrRdata[11] = i_meip;
            end
            CSR_MTVEC:  o_csrRdata = r_mtvec;
            CSR_MEPC:   o_csrRdata = r_mepc;
            CSR_MCAUSE: o_csrRdata = r_mcause;
            CSR_MTVAL:  o_csrRdata = r_mtval;
            default: ;
        endcase
    end

endmodule

// File: doc/trap_controller.md
# trap_controller

Sequencer for privilege-mode changes in the RV32 M/U core: arbitrates synchronous exceptions, `mret` and machine interrupts. It drains the pipeline, commits the trap CSRs, and drives the enable/next-mode pair of the privilege-mode register. It sits between decode/execute (event sources), the CSR file (read/write port) and the fetch unit (PC redirect).

## Interface
Parameters:
- XLEN, 32, datapath width
- MTVEC_RESET, 32'h0000_0000, mtvec reset value

Ports:
- clk  in  1  clock
- reset_x  in  1  reset, asynchronous, active-low
- i_exc  in  1  synchronous exception request
- i_excCause  in  4  exception code (mcause[3:0])
- i_excTval  in  XLEN  faulting address/instruction
- i_mret  in  1  mret retiring
- i_epc  in  XLEN  PC of faulting/mret instruction, or next PC for interrupts
- i_meip / i_msip / i_mtip  in  1 each  external / software / timer interrupt lines
- i_nowPrivMode  in  2  current mode from privilege-mode register
- i_pipeIdle  in  1  pipeline drained acknowledge
- i_csrWe  in  1  software CSR write
- i_csrAddr  in  12  CSR address
- i_csrWdata  in  XLEN  write data
- o_csrRdata  out  XLEN  combinational read data for i_csrAddr
- o_stall  out  1  hold fetch/decode
- o_flush  out  1  kill in-flight instructions
- o_redirect  out  1  one-cycle PC redirect strobe
- o_redirectPc  out  XLEN  redirect target
- o_privEnable  out  1  privilege register load enable
- o_nextPrivMode  out  2  privilege register load value

## Operation
- Owned state: mstatus.MIE/MPIE/MPP, mie (bits 3, 7, 11), mtvec, mepc, mcause, mtval. mip is read-only and reflects the live lines.
- Interrupts are enabled when mode = U, or when mode = M and MIE = 1. Pending = line AND mie bit.
- Priority, sampled only in IDLE: exception > mret > MEI(11) > MSI(3) > MTI(7).
- `mret` with i_nowPrivMode = U is an illegal instruction: cause 2, mtval 0.
- FSM states: IDLE, DRAIN, COMMIT.
  - IDLE → DRAIN on any selected event. Cause, epc, tval and kind are latched.
  - DRAIN → COMMIT when i_pipeIdle = 1.
  - COMMIT → IDLE unconditionally.
- Events arriving in DRAIN/COMMIT are ignored. Requesters hold them, and interrupts remain pending.
- Trap commit:
  - MPP ← i_nowPrivMode, MPIE ← MIE, MIE ← 0
  - mepc ← epc with bits [1:0] cleared
  - mcause ← {interrupt bit XLEN-1, code}
  - mtval ← tval (0 for interrupts)
  - next mode M; target mtvec base
- mret commit: next mode ← MPP, MIE ← MPIE, MPIE ← 1, MPP ← U; target mepc.
- Software CSR writes apply only in IDLE. Writes to mip/unknown addresses are ignored and read 0. MPP writes of 01/10 are stored as U.

## Timing
- Reset: state IDLE. All outputs 0. MIE = MPIE = 0, MPP = M (2'b11). mie/mepc/mcause/mtval = 0, mtvec = MTVEC_RESET.
- Event seen in IDLE at cycle N → DRAIN at N+1: o_stall = o_flush = 1, held until COMMIT.
- i_pipeIdle high in DRAIN at cycle M → COMMIT at M+1: o_stall = 1, o_flush = 0, o_redirect = o_privEnable = 1 for exactly that cycle. CSRs update on the clock edge ending COMMIT.
- Minimum event-to-redirect latency: 2 cycles.
- reset_x low mid-sequence: immediate return to IDLE. No CSR or privilege update is committed.

## Configuration
- TRAP_VECTORED_EN defined:
  - mtvec[1:0] = 01 makes interrupts target base + 4×code.
  - Exceptions always target base.
  - mtvec[1:0] writable as 00/01; 1x is stored as 00.
- Undefined: mtvec[1:0] hardwired 00, and all traps target base.

## Structure
- Package trap_pkg holds:
  - state enum
  - privilege encodings (U = 2'b00, M = 2'b11)
  - CSR addresses: mstatus 0x300, mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344
  - cause codes: 2, 3, 7, 11
- Sub-module trap_priority_sel: combinational event select plus cause/kind encode.

## Test plan
- U mode, i_exc cause 8, epc 0x100, mtvec 0x200, i_pipeIdle already 1 → redirect to 0x200 two cycles later, mode M, mcause 8, mepc 0x100, MPP = U.
- In M mode with MPP = U and mepc 0x104, issue i_mret. Expected: redirect to 0x104, o_nextPrivMode U, MIE = old MPIE, MPIE = 1.
- M mode, MIE = 0, i_mtip = 1, mie[7] = 1 → no event. Write MIE = 1 → trap with mcause 0x8000_0007.
- i_meip + i_mtip + i_exc together → exception taken. After mret, MEI is taken before MTI.
- i_pipeIdle held low 5 cycles → o_flush/o_stall held for 5 cycles, no redirect. Assert reset_x in DRAIN → all reset values, no commit.
- With TRAP_VECTORED_EN, mtvec 0x201, MSI → target 0x20C. Without the macro, mtvec reads 0x200 and the target is 0x200.
